// File: rtl/single_clk_ram_mul.sv
// single_clk_ram_mul: single-port synchronous RAM with one shared address.
// Reads are registered and take one cycle. A word is written only when both
// we and write_enable are high. A synchronous, active-high rst clears q and
// every memory word on the same edge, and it takes priority over a write.
// Optional feature macro: WRITE_THROUGH_EN. When it is defined, a write cycle
// returns the new data on q. When it is undefined, a write cycle returns the
// old word on q (read-before-write).
module single_clk_ram_mul #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] q,
    input  logic                  write_enable,
    input  logic                  rst
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Power-up contents are all zeros, so a read before any write returns 0.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] q_r = '0;
    logic                  wr_en;

    // A write needs both qualifiers.
    assign wr_en = we & write_enable;

    // Storage update: rst clears every word, otherwise perform the gated write.
    // NOTE: clearing every word on rst forces the array into flip-flops,
    // because block RAM cannot be reset. Here that is intended.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= data;
        end
    end

    // Registered read port. It returns the old word on a write cycle unless
    // write-through is built in.
    // NOTE: non-blocking reads of mem see the value from before this edge's
    // write. That is what gives read-before-write with no extra logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= '0;
        end else begin
`ifdef WRITE_THROUGH_EN
            if (wr_en) begin
                q_r <= data;
            end else begin
                q_r <= mem[addr];
            end
`else
            q_r <= mem[addr];
`endif
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_single_clk_ram_mul.sv
// Self-checking bench for single_clk_ram_mul.
// A behavioural array model predicts q on every cycle. Literal checks pin the
// directed scenarios: reset, write/read, gating, read-during-write,
// nibble-accumulate, and reset versus write.
module tb_single_clk_ram_mul;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data = '0;
    logic [AW-1:0] addr = '0;
    logic          we = 1'b0;
    logic          write_enable = 1'b0;
    logic [DW-1:0] q;

    int tests  = 0;
    int failed = 0;
    bit cmp_en = 1'b1;

    // Behavioural model state.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_q = '0;

    single_clk_ram_mul #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .data         (data),
        .addr         (addr),
        .we           (we),
        .clk          (clk),
        .q            (q),
        .write_enable (write_enable),
        .rst          (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the memory starts as zeros, reset wipes it, and a write needs both enables.
    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
    end

    // Model update. Inputs are stable here because they change only at negedge.
    always @(posedge clk) begin
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_q = '0;
        end else begin
            m_q = m_mem[addr];
            if (we && write_enable) begin
`ifdef WRITE_THROUGH_EN
                m_q = data;
`endif
                m_mem[addr] = data;
            end
        end
    end

    // Compare q against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) check("q_vs_model", q, m_q);
    end

    // Drive one cycle of inputs at the falling edge.
    task automatic step(input logic r, input logic w, input logic wen,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rst = r; we = w; write_enable = wen; addr = a; data = d;
    endtask

    // Check q just after the edge that consumes the last step.
    task automatic lit(input string name, input logic [DW-1:0] exp);
        @(posedge clk);
        #1;
        check(name, q, exp);
    endtask

    // Capture q just after the edge that consumes the last step.
    task automatic sample(output logic [DW-1:0] v);
        @(posedge clk);
        #1;
        v = q;
    endtask

    logic [DW-1:0] cur;
    logic [DW-1:0] nd;

    initial begin
        // Power-up: a read before any write or reset returns 0.
        step(0, 0, 0, 7'd10, '0);
        lit("powerup_read", 16'h0000);

        // Reset clears a written word.
        step(0, 1, 1, 7'd5, 16'hFFFF);
        step(0, 1, 1, 7'd64, 16'h5555);
        step(0, 0, 0, 7'd5, '0);
        lit("pre_reset_addr5", 16'hFFFF);
        step(1, 0, 0, 7'd0, '0);
        lit("reset_q_zero", 16'h0000);
        step(0, 0, 0, 7'd5, '0);
        lit("reset_clears_addr5", 16'h0000);
        step(0, 0, 0, 7'd64, '0);
        lit("reset_clears_addr64", 16'h0000);

        // Write/read at the top address, then read address 0.
        step(0, 1, 1, 7'h7F, 16'hA5C3);
        step(0, 0, 0, 7'h7F, '0);
        lit("read_addr_7f", 16'hA5C3);
        step(0, 0, 0, 7'h00, '0);
        lit("read_addr_00", 16'h0000);

        // Gating: a single qualifier must not write.
        step(0, 1, 0, 7'd3, 16'h1234);
        step(0, 0, 0, 7'd3, '0);
        lit("gate_we_only", 16'h0000);
        step(0, 0, 1, 7'd3, 16'h1234);
        step(0, 0, 0, 7'd3, '0);
        lit("gate_wen_only", 16'h0000);

        // Read-during-write on the same address.
        step(0, 1, 1, 7'd9, 16'h000F);
        step(0, 1, 1, 7'd9, 16'h00F0);
`ifdef WRITE_THROUGH_EN
        lit("rdw_write_through", 16'h00F0);
`else
        lit("rdw_old_word", 16'h000F);
`endif
        step(0, 0, 0, 7'd9, '0);
        lit("rdw_follow_read", 16'h00F0);

        // Nibble-accumulate at address 2. Each new word is built from the prior read.
        step(0, 0, 0, 7'd2, '0);
        sample(cur);
        for (int i = 0; i < 4; i++) begin
            nd = cur | DW'((i + 1) << (4 * i));
            step(0, 1, 1, 7'd2, nd);
`ifdef WRITE_THROUGH_EN
            sample(cur);
`else
            step(0, 0, 0, 7'd2, '0);
            sample(cur);
`endif
        end
        step(0, 0, 0, 7'd2, '0);
        lit("nibble_accumulate", 16'h4321);

        // Reset overrides a simultaneous write.
        step(1, 1, 1, 7'd1, 16'hBEEF);
        lit("rst_vs_write_q", 16'h0000);
        step(0, 0, 0, 7'd1, '0);
        lit("rst_vs_write_mem", 16'h0000);

        // A spread of addresses written, then read back through the model check.
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1, AW'(i * 37 + 3), DW'(16'h1000 * (i % 16) + i * 7));
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, AW'(i * 37 + 3), 16'hDEAD);
        end
        step(0, 0, 0, AW'(3), '0);
        lit("spread_read_addr3", 16'h0000);

        step(0, 0, 0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
